fft_8_frame_streamer: RTL and testbench
=======================================

# fft_8_frame_streamer

Streaming front/back end for the 8-point parallel FFT core (`fft_8_sol2_gen3`). It collects eight complex samples from a valid/ready input stream and loads them into the core's parallel input lanes. It then pulses `start`, waits for `done`, captures the eight parallel results and replays them as a valid/ready output stream. Output capture is double-buffered, so the next frame can fill while the previous result drains.

## Interface
- `WIDTH`, default 16: bits per real/imag component.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  block accepts a sample this cycle.
- `s_real`, `s_imag`  in  WIDTH  input sample components.
- `fft_start`  out  1  one-cycle start pulse to the core.
- `fft_in_real`, `fft_in_imag`  out  8*WIDTH  packed core inputs; lane i at [WIDTH*i +: WIDTH].
- `fft_done`  in  1  core completion; rising edge marks a result.
- `fft_out_real`, `fft_out_imag`  in  8*WIDTH  packed core outputs, same lane packing.
- `m_valid`  out  1  output sample valid.
- `m_ready`  in  1  downstream accepts output.
- `m_real`, `m_imag`  out  WIDTH  output bin components.
- `m_index`  out  3  bin number of the current output word.
- `m_last`  out  1  high with bin 7.
- `busy`  out  1  high whenever the input FSM is not in FILL or the output buffer is non-empty.

## Operation
- Input FSM states:
  - FILL: `s_ready`=1. Each `s_valid&&s_ready` writes lane `wr_idx` and increments the 3-bit `wr_idx`. The accept at `wr_idx`=7 goes to LAUNCH and wraps `wr_idx` to 0.
  - LAUNCH: `fft_start`=1 for exactly one cycle, then WAIT.
  - WAIT: waits for the core result, then CAPTURE.
  - CAPTURE: copies `fft_out_*` into the output buffer when it is empty, then returns to FILL.
- `fft_in_*` registers are held stable from LAUNCH until the next FILL write, and never change during WAIT.
- Done detection:
  - `done_seen` is set on the 0→1 edge of `fft_done` (edge detect against a registered copy).
  - `done_seen` is sampled only in WAIT, and cleared when CAPTURE completes.
  - An edge seen outside WAIT is ignored.
- Capture rules:
  - If the output buffer is full when WAIT sees `done_seen`, the FSM stays in WAIT.
  - The core holds its outputs until the next start, and no start is issued before capture, so stalling in WAIT is safe.
  - Capture occurs in the cycle after the buffer empties.
- Output side:
  - States are EMPTY and DRAIN. Capture sets DRAIN with `rd_idx`=0.
  - In DRAIN: `m_valid`=1, `m_real`/`m_imag` = lane `rd_idx`, `m_index`=`rd_idx`, `m_last`=(`rd_idx`==7).
  - On `m_valid&&m_ready`, `rd_idx` increments. The handshake with `m_last` returns to EMPTY.
  - Output data is stable while `m_valid&&!m_ready`.
- Simultaneous events:
  - The final output handshake and a pending capture in the same cycle: the buffer is EMPTY after the edge, and capture happens on the next edge (no bypass).
  - FILL is independent of DRAIN.
- No arithmetic is performed; data passes bit-exact, with no width change.

## Timing
- Reset values:
  - `s_ready`=0 during reset, then 1 in the first cycle after release.
  - `fft_start`=0, `m_valid`=0, `m_last`=0, `m_index`=0, `busy`=0.
  - `fft_in_*`=0, `m_real`/`m_imag`=0, both FSMs in FILL/EMPTY, `done_seen`=0.
- Latencies:
  - 8th input accept → `fft_start` high on the next cycle.
  - `fft_done` rising edge (buffer empty) → WAIT sees it 1 cycle later → CAPTURE next → `m_valid` high 3 cycles after the edge.
  - Minimum frame period = 8 fill + 1 launch + core latency + 2 cycles.
- `s_ready` drops the cycle after the 8th accept and rises the cycle after CAPTURE.
- Reset asserted mid-frame:
  - All state clears immediately; partial input and output frames are discarded.
  - `fft_start` and `m_valid` drop asynchronously.

## Structure
- Shared package `fft_pkg`:
  - `FFT_N`=8 and `FFT_LOG2N`=3.
  - Input and output state enumerations.
  - The lane-slice helper function `lane(bus, i)`.
- One sub-module is natural: `fft_8_frame_buffer`, an 8×(2·WIDTH) register file with a parallel-load port and an indexed read, instantiated for the output buffer.
- The input lanes are plain registers in the top level.

## Test plan
The bench uses a stub core: `fft_done` pulses 5 cycles after `fft_start`, and out lane i = in lane 7−i. The real core is used only in a final smoke run.
- Single frame, `m_ready`=1: inputs real=0x0010·k, imag=0xFFF0−k, k=0..7.
  - Expect `fft_start` on the cycle after the 8th accept.
  - Then 8 outputs with `m_index` 0..7, real 0x0070 down to 0x0000, `m_last` only on index 7.
- Backpressure: `m_ready` toggled 1010… during drain.
  - Each word is held unchanged while stalled.
  - Exactly 8 handshakes occur; no duplicate or lost bins.
- Overlap, `m_ready`=0 for 40 cycles: push two frames (A then B).
  - B fills during A's drain stall.
  - FSM waits in WAIT with B's done seen.
  - After release, A's bins come out, then B's bins, with no gap larger than 1 cycle.
- Spurious done: pulse `fft_done` during FILL.
  - No capture; `m_valid` stays 0.
- Reset mid-operation: assert `rst`=0 after the 5th input sample, release, then send a full frame.
  - All outputs are at their reset values while reset is asserted.
  - Only the new frame appears, and `wr_idx` restarted at lane 0.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 8-point FFT streaming wrapper:
//   FFT_N / FFT_LOG2N  : transform size and lane-index width
//   in_state_e         : input-side FSM states (FILL, LAUNCH, WAIT, CAPTURE)
//   out_state_e        : output-side FSM states (EMPTY, DRAIN)
//   lane()             : extracts lane i of width w from a packed lane bus
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_LOG2N  = 3;

  // Widest component lane() can slice; callers zero-extend into lane_bus_t.
  localparam int LANE_MAX_W = 64;

  typedef logic [FFT_N*LANE_MAX_W-1:0] lane_bus_t;

  typedef enum logic [1:0] {
    IN_FILL    = 2'd0,
    IN_LAUNCH  = 2'd1,
    IN_WAIT    = 2'd2,
    IN_CAPTURE = 2'd3
  } in_state_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_DRAIN = 1'b1
  } out_state_e;

  // Lane i of a bus packed as [w*i +: w]; result is right-aligned and
  // zero-filled above bit w-1.
  function automatic logic [LANE_MAX_W-1:0] lane(input lane_bus_t   bus,
                                                 input int unsigned i,
                                                 input int unsigned w);
    logic [LANE_MAX_W-1:0] mask;
    mask = (w >= LANE_MAX_W) ? '1
                             : ((LANE_MAX_W'(1) << w) - LANE_MAX_W'(1));
    return LANE_MAX_W'(bus >> (i * w)) & mask;
  endfunction

endpackage

// File: rtl/fft_8_frame_buffer.sv
// ---------------------------------------------------------------------------
// fft_8_frame_buffer
// 8 x (2*WIDTH) register file holding one complex result frame.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   load                 : parallel-load all eight lanes this cycle
//   load_real, load_imag : packed source lanes, lane i at [WIDTH*i +: WIDTH]
//   rd_idx               : lane selected for readout
//   rd_real, rd_imag     : combinational read of lane rd_idx
// ---------------------------------------------------------------------------
module fft_8_frame_buffer
  import fft_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [FFT_N*WIDTH-1:0]  load_real,
  input  logic [FFT_N*WIDTH-1:0]  load_imag,
  input  logic [FFT_LOG2N-1:0]    rd_idx,
  output logic [WIDTH-1:0]        rd_real,
  output logic [WIDTH-1:0]        rd_imag
);

  logic [2*WIDTH-1:0] mem [FFT_N];

  // NOTE: this storage is reset (unlike a typical RAM) because the output
  // data port must read as zero straight out of reset; with only eight
  // entries it stays a plain flop array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FFT_N; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      for (int unsigned i = 0; i < FFT_N; i++) begin
        mem[i] <= {WIDTH'(lane(lane_bus_t'(load_real), i, WIDTH)),
                   WIDTH'(lane(lane_bus_t'(load_imag), i, WIDTH))};
      end
    end
  end

  assign {rd_real, rd_imag} = mem[rd_idx];

endmodule

// File: rtl/fft_8_frame_streamer.sv
// ---------------------------------------------------------------------------
// fft_8_frame_streamer
// Collects eight complex samples from a valid/ready stream into the parallel
// input lanes of an 8-point FFT core, pulses fft_start, waits for fft_done,
// captures the eight results into an output buffer and replays them as a
// valid/ready stream. The next frame may fill while the previous one drains.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   s_valid/s_ready/s_real/s_imag: input sample stream
//   fft_start                    : one-cycle start pulse to the core
//   fft_in_real/fft_in_imag      : packed core inputs, lane i at [WIDTH*i +: WIDTH]
//   fft_done                     : core completion, rising edge marks a result
//   fft_out_real/fft_out_imag    : packed core outputs, same packing
//   m_valid/m_ready/m_real/m_imag: output bin stream
//   m_index, m_last              : bin number of the current word, high on bin 7
//   busy                         : frame in flight or output buffer occupied
// ---------------------------------------------------------------------------
module fft_8_frame_streamer
  import fft_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_real,
  input  logic [WIDTH-1:0]        s_imag,
  output logic                    fft_start,
  output logic [FFT_N*WIDTH-1:0]  fft_in_real,
  output logic [FFT_N*WIDTH-1:0]  fft_in_imag,
  input  logic                    fft_done,
  input  logic [FFT_N*WIDTH-1:0]  fft_out_real,
  input  logic [FFT_N*WIDTH-1:0]  fft_out_imag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_real,
  output logic [WIDTH-1:0]        m_imag,
  output logic [FFT_LOG2N-1:0]    m_index,
  output logic                    m_last,
  output logic                    busy
);

  localparam logic [FFT_LOG2N-1:0] LAST_LANE = FFT_LOG2N'(FFT_N - 1);

  in_state_e            in_state;
  out_state_e           out_state;
  logic [FFT_LOG2N-1:0] wr_idx;
  logic [FFT_LOG2N-1:0] rd_idx;
  logic                 done_q;
  logic                 done_seen;

  logic s_fire;
  logic m_fire;
  logic last_fire;
  logic capture_go;
  logic done_edge;

  assign s_fire     = s_valid && s_ready;
  assign m_fire     = m_valid && m_ready;
  assign last_fire  = m_fire && m_last;
  assign capture_go = (in_state == IN_CAPTURE) && (out_state == OUT_EMPTY);
  assign done_edge  = fft_done && !done_q;

  // Edges are only recorded while waiting on our own launch, so a stray
  // pulse during FILL cannot trigger a premature capture later.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q    <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      done_q <= fft_done;
      if (capture_go) begin
        done_seen <= 1'b0;
      end else if (in_state == IN_WAIT && done_edge) begin
        done_seen <= 1'b1;
      end
    end
  end

  // Input side. s_ready and fft_start are registered with the state so they
  // are clean decodes of "next state is FILL" / "next state is LAUNCH".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state    <= IN_FILL;
      wr_idx      <= '0;
      s_ready     <= 1'b0;
      fft_start   <= 1'b0;
      fft_in_real <= '0;
      fft_in_imag <= '0;
    end else begin
      case (in_state)
        IN_FILL: begin
          if (s_fire) begin
            fft_in_real[wr_idx*WIDTH +: WIDTH] <= s_real;
            fft_in_imag[wr_idx*WIDTH +: WIDTH] <= s_imag;
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == LAST_LANE) begin
              in_state  <= IN_LAUNCH;
              s_ready   <= 1'b0;
              fft_start <= 1'b1;
            end
          end else begin
            s_ready <= 1'b1;
          end
        end
        IN_LAUNCH: begin
          fft_start <= 1'b0;
          in_state  <= IN_WAIT;
        end
        IN_WAIT: begin
          // The final output handshake frees the buffer on this edge, so the
          // capture state can load on the very next one without a bypass.
          if (done_seen && (out_state == OUT_EMPTY || last_fire)) begin
            in_state <= IN_CAPTURE;
          end
        end
        IN_CAPTURE: begin
          if (out_state == OUT_EMPTY) begin
            in_state <= IN_FILL;
            s_ready  <= 1'b1;
          end
        end
        default: begin
          in_state <= IN_FILL;
        end
      endcase
    end
  end

  // Output side: replay the captured frame one bin per handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state <= OUT_EMPTY;
      rd_idx    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      case (out_state)
        OUT_EMPTY: begin
          if (capture_go) begin
            out_state <= OUT_DRAIN;
            rd_idx    <= '0;
            m_valid   <= 1'b1;
            m_last    <= 1'b0;
          end
        end
        OUT_DRAIN: begin
          if (m_fire) begin
            rd_idx <= rd_idx + 1'b1;
            m_last <= (rd_idx == LAST_LANE - 1'b1);
            if (m_last) begin
              out_state <= OUT_EMPTY;
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
            end
          end
        end
        default: begin
          out_state <= OUT_EMPTY;
        end
      endcase
    end
  end

  fft_8_frame_buffer #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (capture_go),
    .load_real (fft_out_real),
    .load_imag (fft_out_imag),
    .rd_idx    (rd_idx),
    .rd_real   (m_real),
    .rd_imag   (m_imag)
  );

  assign m_index = rd_idx;
  assign busy    = (in_state != IN_FILL) || (out_state != OUT_EMPTY);

endmodule

// File: tb/tb_fft_8_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft_8_frame_streamer
// Drives fft_8_frame_streamer against a stub core (done 5 cycles after start,
// output lane i = input lane 7-i) and compares the output stream with a
// frame-level reference model: every eight accepted samples form a frame
// whose bin j is the (7-j)th sample of that frame.
// ---------------------------------------------------------------------------
module tb_fft_8_frame_streamer;

  localparam int W = 16;
  localparam int N = 8;

  localparam int RDY_ON     = 0;
  localparam int RDY_TOGGLE = 1;
  localparam int RDY_OFF    = 2;
  localparam int RDY_RAND   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [W-1:0]    s_real;
  logic [W-1:0]    s_imag;
  logic            fft_start;
  logic [N*W-1:0]  fft_in_real;
  logic [N*W-1:0]  fft_in_imag;
  logic            fft_done;
  logic [N*W-1:0]  stub_re = '0;
  logic [N*W-1:0]  stub_im = '0;
  logic            stub_done = 1'b0;
  logic            spur_done;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [W-1:0]    m_real;
  logic [W-1:0]    m_imag;
  logic [2:0]      m_index;
  logic            m_last;
  logic            busy;

  always #5 clk = ~clk;

  assign fft_done = stub_done | spur_done;

  fft_8_frame_streamer #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_real       (s_real),
    .s_imag       (s_imag),
    .fft_start    (fft_start),
    .fft_in_real  (fft_in_real),
    .fft_in_imag  (fft_in_imag),
    .fft_done     (fft_done),
    .fft_out_real (stub_re),
    .fft_out_imag (stub_im),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_real       (m_real),
    .m_imag       (m_imag),
    .m_index      (m_index),
    .m_last       (m_last),
    .busy         (busy)
  );

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } sample_t;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [2:0]   idx;
    logic         last;
  } word_t;

  sample_t in_q[$];
  word_t   exp_q[$];

  int n_tests   = 0;
  int n_fail    = 0;
  int hs_count  = 0;
  int gap_run   = 0;
  int gap_max   = 0;
  bit track_gap = 1'b0;
  int rdy_mode  = RDY_ON;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stub core: result lanes reversed, done pulse five cycles after start.
  int stub_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      stub_cnt  = 0;
      stub_done = 1'b0;
    end else begin
      stub_done = 1'b0;
      if (fft_start) begin
        stub_cnt = 5;
        for (int i = 0; i < N; i++) begin
          stub_re[i*W +: W] = fft_in_real[(N-1-i)*W +: W];
          stub_im[i*W +: W] = fft_in_imag[(N-1-i)*W +: W];
        end
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) stub_done = 1'b1;
      end
    end
  end

  // Downstream ready pattern, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      RDY_ON:     m_ready = 1'b1;
      RDY_TOGGLE: m_ready = ~m_ready;
      RDY_OFF:    m_ready = 1'b0;
      default:    m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: handshakes against the model, stability under stall.
  logic [2*W+4:0] held;
  bit             prev_stall = 1'b0;
  word_t          mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      gap_run    = 0;
    end else begin
      if (prev_stall)
        check("hold_word", 64'({m_valid, m_last, m_index, m_real, m_imag}), 64'(held));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 64'(m_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_real",  64'(m_real),  64'(mon_e.re));
          check("out_imag",  64'(m_imag),  64'(mon_e.im));
          check("out_index", 64'(m_index), 64'(mon_e.idx));
          check("out_last",  64'(m_last),  64'(mon_e.last));
        end
        hs_count++;
      end
      prev_stall = m_valid && !m_ready;
      held       = {m_valid, m_last, m_index, m_real, m_imag};
      if (track_gap) begin
        if (!m_valid && exp_q.size() != 0) gap_run++;
        else gap_run = 0;
        if (gap_run > gap_max) gap_max = gap_run;
      end
    end
  end

  // Offer one sample (after `gap` idle cycles) and record it once accepted.
  task automatic push(input logic [W-1:0] re, input logic [W-1:0] im, input int gap);
    int      waited;
    sample_t s;
    word_t   we;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    waited  = 0;
    while (!s_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      check("push_stalled", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      s.re = re;
      s.im = im;
      in_q.push_back(s);
      if (in_q.size() == N) begin
        for (int j = 0; j < N; j++) begin
          we.re   = in_q[N-1-j].re;
          we.im   = in_q[N-1-j].im;
          we.idx  = 3'(j);
          we.last = (j == N-1);
          exp_q.push_back(we);
        end
        in_q.delete();
      end
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic push_random(input int count, input int max_gap);
    for (int k = 0; k < count; k++)
      push(W'($urandom), W'($urandom), int'($urandom_range(0, max_gap)));
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || m_valid) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int lat;
    int vcount;

    rst       = 1'b0;
    s_valid   = 1'b0;
    s_real    = '0;
    s_imag    = '0;
    spur_done = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_s_ready",   64'(s_ready),     64'd0);
    check("rst_fft_start", 64'(fft_start),   64'd0);
    check("rst_m_valid",   64'(m_valid),     64'd0);
    check("rst_m_last",    64'(m_last),      64'd0);
    check("rst_m_index",   64'(m_index),     64'd0);
    check("rst_busy",      64'(busy),        64'd0);
    check("rst_fft_in_re", 64'(fft_in_real), 64'd0);
    check("rst_fft_in_im", 64'(fft_in_imag), 64'd0);
    check("rst_m_real",    64'(m_real),      64'd0);
    check("rst_m_imag",    64'(m_imag),      64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("s_ready_after_release", 64'(s_ready), 64'd1);

    // Single frame with a fixed pattern and full-rate drain.
    rdy_mode = RDY_ON;
    hs0 = hs_count;
    for (int k = 0; k < N; k++)
      push(W'(16'h0010 * k), W'(16'hFFF0 - k), 0);
    check("start_after_8th",  64'(fft_start), 64'd1);
    check("s_ready_dropped",  64'(s_ready),   64'd0);
    check("busy_in_frame",    64'(busy),      64'd1);
    @(negedge clk);
    check("start_one_cycle",  64'(fft_start), 64'd0);
    lat = 1;
    while (!m_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("start_to_valid", 64'(lat), 64'd8);
    check("first_bin_real", 64'(m_real), 64'h0070);
    drain("single_drain", 100);
    check("single_handshakes", 64'(hs_count - hs0), 64'd8);
    check("idle_s_ready", 64'(s_ready), 64'd1);
    check("idle_busy",    64'(busy),    64'd0);

    // Alternating backpressure.
    rdy_mode = RDY_TOGGLE;
    hs0 = hs_count;
    push_random(N, 0);
    drain("bp_drain", 200);
    check("bp_handshakes", 64'(hs_count - hs0), 64'd8);

    // Overlap: frame B fills and completes while frame A is stalled.
    rdy_mode = RDY_OFF;
    @(negedge clk);
    hs0 = hs_count;
    push_random(2 * N, 0);
    repeat (12) @(negedge clk);
    check("ovl_done_seen",  64'(dut.done_seen), 64'd1);
    check("ovl_m_valid",    64'(m_valid),       64'd1);
    check("ovl_m_index",    64'(m_index),       64'd0);
    check("ovl_s_ready",    64'(s_ready),       64'd0);
    check("ovl_stalled_hs", 64'(hs_count - hs0), 64'd0);
    gap_max   = 0;
    track_gap = 1'b1;
    rdy_mode  = RDY_ON;
    drain("ovl_drain", 200);
    track_gap = 1'b0;
    check("ovl_handshakes", 64'(hs_count - hs0), 64'd16);
    check("ovl_gap_le1",    64'(gap_max <= 1),   64'd1);

    // Spurious done during FILL must not capture anything.
    rdy_mode = RDY_ON;
    push_random(3, 0);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    vcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid) vcount++;
    end
    check("spur_no_valid",  64'(vcount),        64'd0);
    check("spur_done_seen", 64'(dut.done_seen), 64'd0);
    check("spur_s_ready",   64'(s_ready),       64'd1);
    push_random(5, 1);
    drain("spur_drain", 200);

    // Reset mid-operation with a full output buffer and a partial input frame.
    rdy_mode = RDY_OFF;
    push_random(N, 0);
    lat = 0;
    while (!m_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("c_captured", 64'(m_valid), 64'd1);
    push_random(5, 0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid",   64'(m_valid),     64'd0);
    check("mid_rst_fft_start", 64'(fft_start),   64'd0);
    check("mid_rst_s_ready",   64'(s_ready),     64'd0);
    check("mid_rst_busy",      64'(busy),        64'd0);
    check("mid_rst_m_index",   64'(m_index),     64'd0);
    check("mid_rst_m_real",    64'(m_real),      64'd0);
    check("mid_rst_fft_in",    64'(fft_in_real), 64'd0);
    in_q.delete();
    exp_q.delete();
    rdy_mode = RDY_ON;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hs0 = hs_count;
    for (int k = 0; k < N; k++)
      push(W'(16'h0A00 + k), W'(16'h5000 + 3 * k), 0);
    drain("post_rst_drain", 200);
    check("post_rst_handshakes", 64'(hs_count - hs0), 64'd8);

    // Randomized soak: random input gaps and random downstream ready.
    rdy_mode = RDY_RAND;
    push_random(4 * N, 2);
    drain("soak_drain", 2000);
    rdy_mode = RDY_ON;
    repeat (3) @(negedge clk);
    check("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
